mem_load_tracker: RTL and testbench
===================================

// Module: mem_load_tracker
// PURPOSE
//  Parametrised MEM-stage request tracker and load-result formatter. Holds up to DEPTH in-flight data-SRAM
//  transactions (loads and stores) between address acceptance and data_ok. Retires them in order to WB via
//  a valid/ready handshake. Responses belonging to flushed (exception/ertn) instructions are silently
//  discarded. Sits between EX (issue side) and WB; replaces single-outstanding MEM-stage stalling.
// PARAMETERS
//  DEPTH   2   max outstanding transactions, >=1 (power of two not required)
//  DATA_W  32  data_sram_rdata / result width (32 only for LA32R; byte lanes = DATA_W/8)
//  META_W  64  opaque WB payload carried per entry (pc, rf_waddr, rf_we, csr bits, ...)
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high
//  flush          in   1               cancel every entry present before this edge
//  issue_valid    in   1               EX request accepted by SRAM this cycle (req & addr_ok)
//  issue_ready    out  1               tracker not full; EX must not issue when low
//  issue_is_load  in   1               1=load, 0=store
//  issue_ld_ctrl  in   5               {ld_w, ld_b, ld_bu, ld_h, ld_hu}, one-hot or 0 for store
//  issue_addr_lo  in   2               address bits [1:0]
//  issue_meta     in   META_W          payload returned with result
//  data_ok        in   1               in-order SRAM response strobe
//  data_rdata     in   DATA_W          response data
//  out_valid      out  1               head entry complete, presented to WB
//  out_ready      in   1               WB accepts head
//  out_result     out  DATA_W          formatted load data (0 for store)
//  out_is_load    out  1               head is a load
//  out_meta       out  META_W          head payload
//  pending_cnt    out  clog2(DEPTH+1)  occupied entries, incl. cancelled
//  empty          out  1               pending_cnt==0
// BEHAVIOUR
//  - Entry state per slot: FREE -> WAIT (issue) -> DONE (data_ok) -> FREE (out handshake).
//    WAIT -flush-> CANCEL -data_ok-> FREE. DONE -flush-> FREE.
//  - Three circular pointers mod DEPTH: alloc (issue), resp (next WAIT/CANCEL to receive data_ok),
//    head (next to retire); explicit wrap at DEPTH-1 -> 0. Occupancy counter, not pointer compare.
//  - Reset: all slots FREE, pointers 0, out_valid=0, issue_ready=1, pending_cnt=0, empty=1, out_*=0.
//  - issue_ready = (pending_cnt < DEPTH) & ~flush; issue_valid while ~issue_ready is ignored (assert).
//  - data_ok at edge t: rdata formatted and stored in slot resp; out_valid visible from t+1 if that slot is
//    head. No combinational data_ok->out path. data_ok cannot be back-pressured: storage is per slot.
//  - Format: ld_w -> rdata; ld_b/bu -> byte addr_lo, sign-ext for ld_b; ld_h/hu -> half addr_lo[1],
//    sign-ext for ld_h; store -> 0. Formatting done at capture, not at output.
//  - out_valid = head slot DONE & ~flush. Retire on out_valid & out_ready; head advances, slot FREE.
//  - flush same edge as issue_valid: issue dropped. Same edge as data_ok: response consumed by slot resp,
//    slot freed (never surfaces). Same edge as out handshake: handshake suppressed (out_valid low).
//  - data_ok with no WAIT/CANCEL slot: ignored, simulation assertion fires.
//  - Simultaneous issue + data_ok + retire on a full tracker: retire frees a slot next cycle only;
//    issue_ready stays based on registered occupancy (no same-cycle bypass).
//  - pending_cnt next = cnt + issue - (retire | cancelled-slot freed by data_ok | DONE slots dropped by flush).
//  - Reset mid-operation: all state discarded; late data_ok after reset is the memory side's responsibility.
// STRUCTURE
//  - Shared package / macro.vh: LD_CTRL bit indices, slot state encoding (FREE/WAIT/DONE/CANCEL, 2 bits).
//  - Sub-module load_formatter (combinational: rdata, addr_lo, ld_ctrl -> result); reused by other stages.
//  - Slot array, pointers and counter in this module; one always block per pointer.
// TESTING
//  1 Reset, then ld_w addr_lo=0, data_ok rdata=32'h8765_4321 next cycle -> out_valid 1 cycle later,
//    out_result=32'h8765_4321, pending_cnt 1->0 after out_ready.
//  2 ld_b addr_lo=3, rdata=32'h80xx_xxxx -> 32'hFFFF_FF80; ld_bu same -> 32'h0000_0080;
//    ld_h addr_lo=2, rdata=32'h8001_0000 -> 32'hFFFF_8001.
//  3 DEPTH=2: issue 2 loads, no data_ok -> issue_ready=0, pending_cnt=2; third issue ignored; 1st data_ok ->
//    retired with out_ready=1 -> issue_ready returns 1 next cycle; pointers wrap correctly over 10 issues.
//  4 Issue 2 loads, flush before any data_ok -> both CANCEL, out_valid stays 0 through both data_ok,
//    pending_cnt 2->1->0, new load issued afterwards returns its own data.
//  5 Load DONE with out_ready=0 held 5 cycles -> out_* stable; flush -> out_valid 0 same cycle, slot freed.
//  6 flush coincident with issue_valid and data_ok -> issued entry absent, response dropped, empty=1 after.

Source files
------------

// File: rtl/mem_load_tracker_pkg.sv
// rtl/mem_load_tracker_pkg.sv - shared slot-state encoding and load-control bit indices
package mem_load_tracker_pkg;

    // Per-slot lifecycle of an in-flight SRAM transaction
    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_WAIT   = 2'd1,
        SLOT_DONE   = 2'd2,
        SLOT_CANCEL = 2'd3
    } slot_state_e;

    // Bit positions inside the {ld_w, ld_b, ld_bu, ld_h, ld_hu} control vector
    localparam int LD_CTRL_W = 5;
    localparam int LD_W      = 4;
    localparam int LD_B      = 3;
    localparam int LD_BU     = 2;
    localparam int LD_H      = 1;
    localparam int LD_HU     = 0;

endpackage

// File: rtl/mem_load_tracker_load_formatter.sv
// rtl/mem_load_tracker_load_formatter.sv - combinational load-result lane select and extension
module load_formatter
    import mem_load_tracker_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]    i_rdata,
    input  logic [1:0]           i_addr_lo,
    input  logic [LD_CTRL_W-1:0] i_ld_ctrl,
    output logic [DATA_W-1:0]    o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[16 +: 16] : i_rdata[0 +: 16];

    // Pick the addressed lane and extend it; a store (no ctrl bit set) yields zero
    always_comb begin
        o_result = '0;
        if (i_ld_ctrl[LD_W])
            o_result = i_rdata;
        else if (i_ld_ctrl[LD_B])
            o_result = {{(DATA_W-8){w_byte[7]}}, w_byte};
        else if (i_ld_ctrl[LD_BU])
            o_result = {{(DATA_W-8){1'b0}}, w_byte};
        else if (i_ld_ctrl[LD_H])
            o_result = {{(DATA_W-16){w_half[15]}}, w_half};
        else if (i_ld_ctrl[LD_HU])
            o_result = {{(DATA_W-16){1'b0}}, w_half};
    end

endmodule

// File: rtl/mem_load_tracker.sv
// rtl/mem_load_tracker.sv - in-order tracker of outstanding data-SRAM transactions feeding WB
module mem_load_tracker
    import mem_load_tracker_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter int  DATA_W = 32,
    parameter int  META_W = 64,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 issue_is_load,
    input  logic [LD_CTRL_W-1:0] issue_ld_ctrl,
    input  logic [1:0]           issue_addr_lo,
    input  logic [META_W-1:0]    issue_meta,
    input  logic                 data_ok,
    input  logic [DATA_W-1:0]    data_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_result,
    output logic                 out_is_load,
    output logic [META_W-1:0]    out_meta,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic                 empty
);

    slot_state_e          r_state   [DEPTH];
    logic [DATA_W-1:0]    r_result  [DEPTH];
    logic [META_W-1:0]    r_meta    [DEPTH];
    logic                 r_is_load [DEPTH];
    logic [LD_CTRL_W-1:0] r_ld_ctrl [DEPTH];
    logic [1:0]           r_addr_lo [DEPTH];
    logic [PTR_W-1:0]     r_alloc;
    logic [PTR_W-1:0]     r_resp;
    logic [PTR_W-1:0]     r_head;
    logic [CNT_W-1:0]     r_cnt;

    slot_state_e          w_state_nxt [DEPTH];
    logic [CNT_W-1:0]     w_freed;
    logic [DATA_W-1:0]    w_fmt;
    logic                 w_issue;
    logic                 w_resp_hit;
    logic                 w_cancel_free;
    logic                 w_retire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_issue       = issue_valid & issue_ready;
    assign w_resp_hit    = data_ok & ((r_state[r_resp] == SLOT_WAIT) | (r_state[r_resp] == SLOT_CANCEL));
    assign w_cancel_free = w_resp_hit & (r_state[r_resp] == SLOT_CANCEL);
    assign w_retire      = out_valid & out_ready;

    // Response formatting happens at capture using the control saved at issue
    load_formatter #(.DATA_W(DATA_W)) u_fmt (
        .i_rdata   (data_rdata),
        .i_addr_lo (r_addr_lo[r_resp]),
        .i_ld_ctrl (r_ld_ctrl[r_resp]),
        .o_result  (w_fmt)
    );

    // Slot state register
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            r_state[i] <= reset ? SLOT_FREE : w_state_nxt[i];
    end

    // Slot next-state and count of slots returning to FREE this cycle
    always_comb begin
        w_freed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_issue && r_alloc == PTR_W'(i))
                w_state_nxt[i] = SLOT_WAIT;
            if (w_resp_hit && r_resp == PTR_W'(i))
                w_state_nxt[i] = (flush || r_state[i] == SLOT_CANCEL) ? SLOT_FREE : SLOT_DONE;
            else if (flush) begin
                if (r_state[i] == SLOT_WAIT) w_state_nxt[i] = SLOT_CANCEL;
                if (r_state[i] == SLOT_DONE) w_state_nxt[i] = SLOT_FREE;
            end
            if (w_retire && r_head == PTR_W'(i))
                w_state_nxt[i] = SLOT_FREE;
            if (r_state[i] != SLOT_FREE && w_state_nxt[i] == SLOT_FREE)
                w_freed = w_freed + 1'b1;
        end
    end

    // Head-slot outputs, zeroed whenever nothing is presented
    always_comb begin
        issue_ready = (r_cnt < CNT_W'(DEPTH)) & ~flush;
        out_valid   = (r_state[r_head] == SLOT_DONE) & ~flush;
        out_result  = out_valid ? r_result[r_head]  : '0;
        out_is_load = out_valid ? r_is_load[r_head] : 1'b0;
        out_meta    = out_valid ? r_meta[r_head]    : '0;
        pending_cnt = r_cnt;
        empty       = (r_cnt == '0);
    end

    // Per-slot payload: request attributes at issue, formatted data at response
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_result[i]  <= '0;
                r_meta[i]    <= '0;
                r_is_load[i] <= 1'b0;
                r_ld_ctrl[i] <= '0;
                r_addr_lo[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_meta[r_alloc]    <= issue_meta;
                r_is_load[r_alloc] <= issue_is_load;
                r_ld_ctrl[r_alloc] <= issue_ld_ctrl;
                r_addr_lo[r_alloc] <= issue_addr_lo;
            end
            if (w_resp_hit && !w_cancel_free && !flush)
                r_result[r_resp] <= w_fmt;
        end
    end

    // Allocation pointer advances on every accepted issue
    always_ff @(posedge clk) begin
        if (reset)        r_alloc <= '0;
        else if (w_issue) r_alloc <= ptr_inc(r_alloc);
    end

    // Response pointer advances on every data_ok that finds a waiting or cancelled slot
    always_ff @(posedge clk) begin
        if (reset)           r_resp <= '0;
        else if (w_resp_hit) r_resp <= ptr_inc(r_resp);
    end

    // Head skips dropped DONE slots on flush and steps past cancelled slots as they drain
    always_ff @(posedge clk) begin
        if (reset)
            r_head <= '0;
        else if (flush)
            r_head <= w_resp_hit ? ptr_inc(r_resp) : r_resp;
        else if (w_retire || w_cancel_free)
            r_head <= ptr_inc(r_head);
    end

    // Occupancy counter
    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= r_cnt + CNT_W'(w_issue) - w_freed;
    end

    // Protocol checks on the surrounding pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(issue_valid && !issue_ready))
                else $warning("issue_valid while issue_ready low: request dropped");
            assert (!(data_ok && !w_resp_hit))
                else $error("data_ok with no outstanding slot");
        end
    end

endmodule

// File: tb/tb_mem_load_tracker.sv
// tb/tb_mem_load_tracker.sv - directed self-checking bench for mem_load_tracker
module tb_mem_load_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        issue_is_load = 1'b0;
    logic [4:0]  issue_ld_ctrl = '0;
    logic [1:0]  issue_addr_lo = '0;
    logic [63:0] issue_meta = '0;
    logic        data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_is_load;
    logic [63:0] out_meta;
    logic [1:0]  pending_cnt;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] C_W  = 5'b10000;
    localparam logic [4:0] C_B  = 5'b01000;
    localparam logic [4:0] C_BU = 5'b00100;
    localparam logic [4:0] C_H  = 5'b00010;
    localparam logic [4:0] C_HU = 5'b00001;

    mem_load_tracker #(.DEPTH(2), .DATA_W(32), .META_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_is_load (issue_is_load),
        .issue_ld_ctrl (issue_ld_ctrl),
        .issue_addr_lo (issue_addr_lo),
        .issue_meta    (issue_meta),
        .data_ok       (data_ok),
        .data_rdata    (data_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_is_load   (out_is_load),
        .out_meta      (out_meta),
        .pending_cnt   (pending_cnt),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic is_load, input logic [4:0] ctrl, input logic [1:0] lo, input logic [63:0] meta);
        issue_valid   = 1'b1;
        issue_is_load = is_load;
        issue_ld_ctrl = ctrl;
        issue_addr_lo = lo;
        issue_meta    = meta;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, issue_ready, pending_cnt, empty} !== {1'b0, 1'b1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_flags got v=%b rdy=%b cnt=%0d empty=%b want 0 1 0 1", out_valid, issue_ready, pending_cnt, empty);
        end
        n_tests++;
        if ({out_result, out_is_load, out_meta} !== 97'd0) begin
            n_fail++;
            $display("FAIL reset_outs got res=%h ld=%b meta=%h want zeros", out_result, out_is_load, out_meta);
        end
    endtask

    task automatic test_ld_w();
        set_issue(1'b1, C_W, 2'd0, 64'h1111);
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b1;
        data_rdata  = 32'h8765_4321;
        #1;
        n_tests++;
        if (pending_cnt !== 2'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ldw_wait got cnt=%0d v=%b want 1 0", pending_cnt, out_valid);
        end
        tick();
        data_ok = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_result, out_is_load, out_meta} !== {1'b1, 32'h8765_4321, 1'b1, 64'h1111}) begin
            n_fail++;
            $display("FAIL ldw_out got v=%b res=%h ld=%b meta=%h want 1 87654321 1 1111", out_valid, out_result, out_is_load, out_meta);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_tests++;
        if ({pending_cnt, empty, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ldw_retire got cnt=%0d empty=%b v=%b want 0 1 0", pending_cnt, empty, out_valid);
        end
    endtask

    task automatic test_format();
        logic [4:0]  ctrl  [6] = '{C_B, C_BU, C_H, C_HU, C_B, 5'b00000};
        logic [1:0]  lo    [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2};
        logic [31:0] rdata [6] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_0000, 32'h1234_F00D, 32'h0000_7F00, 32'hFFFF_FFFF};
        logic [31:0] exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00D, 32'h0000_007F, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            set_issue(ctrl[i] != 5'b00000, ctrl[i], lo[i], 64'(300 + i));
            tick();
            issue_valid = 1'b0;
            data_ok     = 1'b1;
            data_rdata  = rdata[i];
            tick();
            data_ok = 1'b0;
            #1;
            n_tests++;
            if ({out_valid, out_result, out_is_load, out_meta} !== {1'b1, exp[i], (ctrl[i] != 5'b00000), 64'(300 + i)}) begin
                n_fail++;
                $display("FAIL format_%0d got v=%b res=%h ld=%b meta=%0d want res=%h", i, out_valid, out_result, out_is_load, out_meta, exp[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_full();
        set_issue(1'b1, C_W, 2'd0, 64'd1);
        tick();
        set_issue(1'b1, C_W, 2'd0, 64'd2);
        tick();
        issue_valid = 1'b0;
        #1;
        n_tests++;
        if ({issue_ready, pending_cnt} !== {1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL full_flags got rdy=%b cnt=%0d want 0 2", issue_ready, pending_cnt);
        end
        set_issue(1'b1, C_W, 2'd0, 64'd3);
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b1;
        data_rdata  = 32'h0000_AAAA;
        #1;
        n_tests++;
        if (pending_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL full_third_ignored got cnt=%0d want 2", pending_cnt);
        end
        tick();
        data_ok = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_meta, out_result, issue_ready} !== {1'b1, 64'd1, 32'h0000_AAAA, 1'b0}) begin
            n_fail++;
            $display("FAIL full_head got v=%b meta=%0d res=%h rdy=%b want 1 1 0000aaaa 0", out_valid, out_meta, out_result, issue_ready);
        end
        out_ready  = 1'b1;
        data_ok    = 1'b1;
        data_rdata = 32'h0000_BBBB;
        set_issue(1'b1, C_W, 2'd0, 64'd4);
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b0;
        out_ready   = 1'b0;
        #1;
        n_tests++;
        if ({pending_cnt, issue_ready, out_valid, out_meta, out_result} !== {2'd1, 1'b1, 1'b1, 64'd2, 32'h0000_BBBB}) begin
            n_fail++;
            $display("FAIL back_to_back got cnt=%0d rdy=%b v=%b meta=%0d res=%h want 1 1 1 2 0000bbbb", pending_cnt, issue_ready, out_valid, out_meta, out_result);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain got empty=%b want 1", empty);
        end
        for (int i = 0; i < 5; i++) begin
            set_issue(1'b1, C_W, 2'd0, 64'(200 + 2 * i));
            tick();
            set_issue(1'b1, C_W, 2'd0, 64'(201 + 2 * i));
            tick();
            issue_valid = 1'b0;
            data_ok     = 1'b1;
            data_rdata  = 32'hD000_0000 + 32'(2 * i);
            tick();
            data_rdata = 32'hD000_0001 + 32'(2 * i);
            out_ready  = 1'b1;
            #1;
            n_tests++;
            if ({out_valid, out_meta, out_result} !== {1'b1, 64'(200 + 2 * i), 32'hD000_0000 + 32'(2 * i)}) begin
                n_fail++;
                $display("FAIL wrap_a_%0d got v=%b meta=%0d res=%h", i, out_valid, out_meta, out_result);
            end
            tick();
            data_ok = 1'b0;
            #1;
            n_tests++;
            if ({out_valid, out_meta, out_result} !== {1'b1, 64'(201 + 2 * i), 32'hD000_0001 + 32'(2 * i)}) begin
                n_fail++;
                $display("FAIL wrap_b_%0d got v=%b meta=%0d res=%h", i, out_valid, out_meta, out_result);
            end
            tick();
            out_ready = 1'b0;
            #1;
            n_tests++;
            if (empty !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_empty_%0d got empty=%b want 1", i, empty);
            end
        end
    endtask

    task automatic test_flush_cancel();
        set_issue(1'b1, C_W, 2'd0, 64'd5);
        tick();
        set_issue(1'b1, C_W, 2'd0, 64'd6);
        tick();
        issue_valid = 1'b0;
        flush       = 1'b1;
        #1;
        n_tests++;
        if (issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_issue got rdy=%b want 0", issue_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        n_tests++;
        if ({pending_cnt, out_valid} !== {2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL cancel_hold got cnt=%0d v=%b want 2 0", pending_cnt, out_valid);
        end
        data_ok    = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        tick();
        #1;
        n_tests++;
        if ({pending_cnt, out_valid} !== {2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL cancel_first got cnt=%0d v=%b want 1 0", pending_cnt, out_valid);
        end
        tick();
        data_ok = 1'b0;
        #1;
        n_tests++;
        if ({pending_cnt, out_valid, empty} !== {2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL cancel_second got cnt=%0d v=%b empty=%b want 0 0 1", pending_cnt, out_valid, empty);
        end
        set_issue(1'b1, C_W, 2'd0, 64'd7);
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b1;
        data_rdata  = 32'h1234_5678;
        tick();
        data_ok = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_meta, out_result} !== {1'b1, 64'd7, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL after_cancel got v=%b meta=%0d res=%h want 1 7 12345678", out_valid, out_meta, out_result);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_hold_flush();
        set_issue(1'b1, C_H, 2'd0, 64'd8);
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b1;
        data_rdata  = 32'hC0DE_8123;
        tick();
        data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({out_valid, out_result, out_meta} !== {1'b1, 32'hFFFF_8123, 64'd8}) begin
                n_fail++;
                $display("FAIL hold_%0d got v=%b res=%h meta=%0d want 1 ffff8123 8", i, out_valid, out_result, out_meta);
            end
            tick();
        end
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_flush_valid got v=%b want 0", out_valid);
        end
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if ({pending_cnt, empty, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_flush_free got cnt=%0d empty=%b v=%b want 0 1 0", pending_cnt, empty, out_valid);
        end
    endtask

    task automatic test_flush_coincident();
        set_issue(1'b1, C_W, 2'd0, 64'd9);
        tick();
        set_issue(1'b1, C_W, 2'd0, 64'd10);
        data_ok    = 1'b1;
        data_rdata = 32'h5555_5555;
        flush      = 1'b1;
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b0;
        flush       = 1'b0;
        #1;
        n_tests++;
        if ({empty, pending_cnt, out_valid} !== {1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL coincident got empty=%b cnt=%0d v=%b want 1 0 0", empty, pending_cnt, out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL coincident_late got v=%b want 0", out_valid);
        end
        set_issue(1'b1, C_B, 2'd2, 64'd11);
        tick();
        issue_valid = 1'b0;
        data_ok     = 1'b1;
        data_rdata  = 32'h6677_7777;
        tick();
        data_ok = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_meta, out_result} !== {1'b1, 64'd11, 32'h0000_0077}) begin
            n_fail++;
            $display("FAIL coincident_next got v=%b meta=%0d res=%h want 1 11 00000077", out_valid, out_meta, out_result);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ld_w();
        test_format();
        test_full();
        test_flush_cancel();
        test_hold_flush();
        test_flush_coincident();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
